ifu_fetch: RTL and testbench

Instruction fetch unit for the Tiny-Vedas in-order core. It owns the architectural fetch PC and issues word-aligned requests to instruction memory over a valid/ready channel. Returned instructions are buffered and handed to decode tagged with their PC. It is the receiving end of the EXU redirect (`pc_out`/`pc_load`): on a taken branch or jump it flushes buffered and in-flight fetches and restarts at the target.

---
 rtl/ifu_fetch.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ifu_fetch.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
//-----------------------------------------------------------------------------
// ifu_fetch -- instruction fetch unit
//
// Owns the architectural fetch PC. Issues word-aligned requests to
// instruction memory over a valid/ready channel. Returned words are buffered
// and handed to decode tagged with the PC they were fetched from. An EXU
// redirect (pc_load/pc_out) flushes buffered and in-flight fetches and
// restarts fetching at the target.
//
// Parameters
//   XLEN          address width
//   RESET_VECTOR  first fetch address after reset (bits [1:0] ignored)
//   DEPTH         instruction buffer entries and maximum outstanding
//                 requests; power of two, at least 2
//
// Ports
//   clk, rst                  core clock; asynchronous active-high reset
//   pc_load, pc_out           redirect strobe and target (bits [1:0] ignored)
//   imem_req_valid/ready/addr fetch request channel
//   imem_rsp_valid/data       in-order fetch responses, latency >= 1
//   instr_valid/ready         instruction handshake towards decode
//   instr, instr_tag          instruction word and its PC
//
// Build option
//   IFU_BYPASS_EN  when defined, a kept response arriving while the buffer is
//                  empty is presented to decode in the same cycle. When
//                  undefined, every kept response goes through the buffer,
//                  adding one cycle of latency.
//-----------------------------------------------------------------------------
`default_nettype none

module ifu_fetch #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     DEPTH        = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_load,
    input  logic [XLEN-1:0] pc_out,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_tag
);

    // Pointer width for DEPTH-entry FIFOs and counter width for 0..DEPTH.
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0]   PTR_ONE   = PW'(1);
    localparam logic [CW-1:0]   CNT_ZERO  = '0;
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW:0]     OCC_LIMIT = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] FPC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] FPC_RESET = RESET_VECTOR & ~XLEN'(3);

    //-------------------------------------------------------------------------
    // State
    //-------------------------------------------------------------------------
    logic            r_rst_q;     // holds fetch off for one cycle after reset
    logic [XLEN-1:0] r_fpc;       // fetch PC
    logic [CW-1:0]   r_osd;       // requests accepted but not yet answered
    logic [CW-1:0]   r_drop;      // responses still to be discarded

    // Tag queue: address of every accepted request, in request order.
    logic [XLEN-1:0] r_tq_mem [DEPTH];
    logic [PW-1:0]   r_tq_wp;
    logic [PW-1:0]   r_tq_rp;

    // Instruction buffer: {word, tag} entries waiting for decode.
    logic [31:0]     r_bd_mem [DEPTH];
    logic [XLEN-1:0] r_bt_mem [DEPTH];
    logic [PW-1:0]   r_b_wp;
    logic [PW-1:0]   r_b_rp;
    logic [CW-1:0]   r_b_cnt;

    //-------------------------------------------------------------------------
    // Combinational control
    //-------------------------------------------------------------------------
    logic [CW:0]     w_occ;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_rsp_in;
    logic            w_rsp_keep;
    logic [XLEN-1:0] w_rsp_tag;
    logic            w_buf_empty;
    logic            w_byp;
    logic            w_out_valid;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_osd_next;
    logic [CW-1:0]   w_drop_next;
    logic [CW-1:0]   w_b_cnt_next;
    logic [XLEN-1:0] w_fpc_next;
    logic [31:0]     w_head_data;
    logic [XLEN-1:0] w_head_tag;

    // The low target bits are architecturally ignored.
    logic w_unused_pc_bits;
    assign w_unused_pc_bits = &{1'b0, pc_out[1:0]};

    // Buffered words plus in-flight requests never exceed DEPTH, so every
    // response is guaranteed a buffer slot (or is consumed / discarded).
    assign w_occ       = {1'b0, r_b_cnt} + {1'b0, r_osd};
    assign w_req_valid = ~r_rst_q & ~pc_load & (w_occ < OCC_LIMIT);
    assign w_req_fire  = w_req_valid & imem_req_ready;

    // No response can exist before the first request after reset.
    assign w_rsp_in   = imem_rsp_valid & ~r_rst_q;
    // A response in a redirect cycle belongs to the old stream.
    assign w_rsp_keep = w_rsp_in & (r_drop == CNT_ZERO) & ~pc_load;
    assign w_rsp_tag  = r_tq_mem[r_tq_rp];

    assign w_buf_empty = (r_b_cnt == CNT_ZERO);
    assign w_head_data = r_bd_mem[r_b_rp];
    assign w_head_tag  = r_bt_mem[r_b_rp];

`ifdef IFU_BYPASS_EN
    assign w_byp = w_rsp_keep & w_buf_empty;
`else
    assign w_byp = 1'b0;
`endif

    assign w_out_valid = ~r_rst_q & ~pc_load & (~w_buf_empty | w_byp);

    // Only the buffer head can be popped; a bypassed word consumed directly
    // is simply never written.
    assign w_pop  = w_out_valid & instr_ready & ~w_buf_empty;
    assign w_push = w_rsp_keep & ~(w_byp & instr_ready);

    always_comb begin
        w_osd_next = r_osd;
        case ({w_req_fire, w_rsp_in})
            2'b10:   w_osd_next = r_osd + CNT_ONE;
            2'b01:   w_osd_next = r_osd - CNT_ONE;
            default: w_osd_next = r_osd;
        endcase
    end

    // On a redirect, everything still in flight at the end of the cycle is
    // stale. Nothing is kept in a redirect cycle, so that is simply the next
    // outstanding count; consecutive redirects therefore recount from scratch
    // and never double-count.
    always_comb begin
        w_drop_next = r_drop;
        if (pc_load) begin
            w_drop_next = w_osd_next;
        end else if (w_rsp_in && (r_drop != CNT_ZERO)) begin
            w_drop_next = r_drop - CNT_ONE;
        end
    end

    always_comb begin
        w_b_cnt_next = r_b_cnt;
        case ({w_push, w_pop})
            2'b10:   w_b_cnt_next = r_b_cnt + CNT_ONE;
            2'b01:   w_b_cnt_next = r_b_cnt - CNT_ONE;
            default: w_b_cnt_next = r_b_cnt;
        endcase
    end

    always_comb begin
        w_fpc_next = r_fpc;
        if (pc_load) begin
            w_fpc_next = {pc_out[XLEN-1:2], 2'b00};
        end else if (w_req_fire) begin
            w_fpc_next = r_fpc + FPC_STEP;
        end
    end

    //-------------------------------------------------------------------------
    // Registers with reset
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_q <= 1'b1;
            r_fpc   <= FPC_RESET;
            r_osd   <= CNT_ZERO;
            r_drop  <= CNT_ZERO;
            r_tq_wp <= '0;
            r_tq_rp <= '0;
            r_b_wp  <= '0;
            r_b_rp  <= '0;
            r_b_cnt <= CNT_ZERO;
        end else begin
            r_rst_q <= 1'b0;
            r_fpc   <= w_fpc_next;
            r_osd   <= w_osd_next;
            r_drop  <= w_drop_next;

            // The tag queue is not flushed on redirect: stale entries are
            // retired one per response as the dropped responses drain.
            if (w_req_fire) begin
                r_tq_wp <= r_tq_wp + PTR_ONE;
            end
            if (w_rsp_in) begin
                r_tq_rp <= r_tq_rp + PTR_ONE;
            end

            if (pc_load) begin
                r_b_wp  <= '0;
                r_b_rp  <= '0;
                r_b_cnt <= CNT_ZERO;
            end else begin
                if (w_push) begin
                    r_b_wp <= r_b_wp + PTR_ONE;
                end
                if (w_pop) begin
                    r_b_rp <= r_b_rp + PTR_ONE;
                end
                r_b_cnt <= w_b_cnt_next;
            end
        end
    end

    //-------------------------------------------------------------------------
    // Storage arrays (no reset; validity is tracked by the pointers)
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_tq_mem[r_tq_wp] <= r_fpc;
        end
        if (w_push) begin
            r_bd_mem[r_b_wp] <= imem_rsp_data;
            r_bt_mem[r_b_wp] <= w_rsp_tag;
        end
    end

    //-------------------------------------------------------------------------
    // Outputs
    //-------------------------------------------------------------------------
    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fpc;
    assign instr_valid    = w_out_valid;

    // Word and tag read as zero whenever nothing is offered to decode, so the
    // outputs are defined from reset even though the arrays are not.
    always_comb begin
        instr     = '0;
        instr_tag = '0;
        if (w_out_valid) begin
            if (!w_buf_empty) begin
                instr     = w_head_data;
                instr_tag = w_head_tag;
            end else begin
                instr     = imem_rsp_data;
                instr_tag = w_rsp_tag;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

`ifdef IFU_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk            = 1'b0;
    logic        rst            = 1'b0;
    logic        pc_load        = 1'b0;
    logic [31:0] pc_out         = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        instr_valid;
    logic        instr_ready    = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_tag;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int lat     = 1;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    pend_t       mem_q[$];     // memory model: accepted requests awaiting response
    logic [31:0] acc_log[$];   // every accepted request address, in order
    logic [31:0] exp_q[$];     // scoreboard: tags decode must receive, in order

    ifu_fetch #(
        .XLEN        (32),
        .RESET_VECTOR(32'h0),
        .DEPTH       (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_load       (pc_load),
        .pc_out        (pc_out),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_tag     (instr_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_9E00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Memory model: record accepts mid-cycle, answer after 'lat' cycles.
    always @(negedge clk) begin : mem_accept
        pend_t p;
        if (rst) begin
            mem_q.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            p.due  = cyc + lat;
            p.addr = imem_req_addr;
            mem_q.push_back(p);
            acc_log.push_back(imem_req_addr);
            $display("[%0d] req   addr=%h", cyc, imem_req_addr);
        end
    end

    always @(posedge clk) begin
        #1;
        imem_rsp_valid = 1'b0;
        if (!rst && mem_q.size() != 0 && mem_q[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
    end

    // Monitor: every decode handshake is compared against the scoreboard.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (!rst && instr_valid && instr_ready) begin
            $display("[%0d] instr tag=%h data=%h", cyc, instr_tag, instr);
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL extra_instr: got tag %h, required no delivery", instr_tag);
            end else begin
                e = exp_q.pop_front();
                chk("instr_tag", instr_tag, e);
                chk("instr_data", instr, mem_word(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Resets DUT and bench state; returns at the start of cycle c0 with
    // reset just released.
    task automatic restart(input int l, input logic rdy, input logic mrdy);
        rst         = 1'b1;
        pc_load     = 1'b0;
        instr_ready = 1'b0;
        tick();
        tick();
        exp_q.delete();
        acc_log.delete();
        lat            = l;
        instr_ready    = rdy;
        imem_req_ready = mrdy;
        rst            = 1'b0;
    endtask

    // Wait (bounded) until the scoreboard is empty, then stop decode.
    task automatic drain(input string name);
        @(posedge clk);
        for (int k = 0; k < 80 && exp_q.size() != 0; k++) @(posedge clk);
        chk({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
        #1;
        instr_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Async reset with no clock edge yet.
        #1 rst = 1'b1;
        #1;
        chk("rst_req_valid",   32'(imem_req_valid), 32'd0);
        chk("rst_req_addr",    imem_req_addr,       32'h0);
        chk("rst_instr_valid", 32'(instr_valid),    32'd0);
        chk("rst_instr",       instr,               32'h0);
        chk("rst_instr_tag",   instr_tag,           32'h0);

        // Reset release, latency 1, decode always ready.
        restart(1, 1'b1, 1'b1);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        sample();
        chk("s1_hold_c0", 32'(imem_req_valid), 32'd0);
        tick(); sample();
        chk("s1_req_valid_c1", 32'(imem_req_valid), 32'd1);
        chk("s1_req_addr_c1",  imem_req_addr,       32'h0);
        tick(); sample();
        chk("s1_instr_valid_c2", 32'(instr_valid), 32'(BYP));
        drain("s1");
        chk("s1_acc0", acc_log[0], 32'h0);
        chk("s1_acc1", acc_log[1], 32'h4);
        chk("s1_acc2", acc_log[2], 32'h8);

        // Backpressure: decode stalled for 10 cycles.
        restart(1, 1'b0, 1'b1);
        repeat (10) tick();
        sample();
        chk("s2_acc_count",   32'(acc_log.size()),  32'd2);
        chk("s2_req_held",    32'(imem_req_valid),  32'd0);
        chk("s2_instr_valid", 32'(instr_valid),     32'd1);
        chk("s2_head_tag",    instr_tag,            32'h0);
        tick();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        instr_ready = 1'b1;
        drain("s2");
        chk("s2_resume_addr", acc_log[2], 32'h8);

        // Redirect with two requests in flight, latency 3.
        restart(3, 1'b1, 1'b1);
        exp_q.push_back(32'h104); exp_q.push_back(32'h108); exp_q.push_back(32'h10C);
        tick(); tick(); tick();
        pc_load = 1'b1; pc_out = 32'h0000_0106;
        sample();
        chk("s3_req_valid_T", 32'(imem_req_valid), 32'd0);
        tick();
        pc_load = 1'b0;
        sample();
        chk("s3_req_addr", imem_req_addr, 32'h104);
        drain("s3");
        chk("s3_first_new_acc", acc_log[2], 32'h104);

        // Redirect in the same cycle a response arrives, one more in flight.
        restart(2, 1'b1, 1'b1);
        exp_q.push_back(32'h200); exp_q.push_back(32'h204); exp_q.push_back(32'h208);
        tick(); tick(); tick();
        pc_load = 1'b1; pc_out = 32'h200;
        sample();
        chk("s4_instr_valid_T", 32'(instr_valid),    32'd0);
        chk("s4_req_valid_T",   32'(imem_req_valid), 32'd0);
        tick();
        pc_load = 1'b0;
        sample();
        chk("s4_req_valid_T1", 32'(imem_req_valid), 32'd1);
        chk("s4_req_addr_T1",  imem_req_addr,       32'h200);
        drain("s4");
        chk("s4_first_new_acc", acc_log[2], 32'h200);

        // Pending request withdrawn, then back-to-back redirects.
        restart(1, 1'b1, 1'b0);
        exp_q.push_back(32'h400); exp_q.push_back(32'h404);
        tick();
        pc_load = 1'b1; pc_out = 32'h300;
        sample();
        chk("s5_withdraw", 32'(imem_req_valid), 32'd0);
        tick();
        pc_out = 32'h400;
        sample();
        chk("s5_req_valid_2nd", 32'(imem_req_valid), 32'd0);
        chk("s5_addr_1st",      imem_req_addr,       32'h300);
        tick();
        pc_load = 1'b0; imem_req_ready = 1'b1;
        sample();
        chk("s5_req_valid", 32'(imem_req_valid), 32'd1);
        chk("s5_req_addr",  imem_req_addr,       32'h400);
        drain("s5");
        chk("s5_first_acc", acc_log[0], 32'h400);

        // Wrap-around of the fetch PC.
        restart(1, 1'b1, 1'b1);
        exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);         exp_q.push_back(32'h4);
        tick();
        pc_load = 1'b1; pc_out = 32'hFFFF_FFF8;
        tick();
        pc_load = 1'b0;
        drain("s6");
        chk("s6_acc0", acc_log[0], 32'hFFFF_FFF8);
        chk("s6_acc1", acc_log[1], 32'hFFFF_FFFC);
        chk("s6_acc2", acc_log[2], 32'h0);

        // Asynchronous reset mid-stream: one word buffered, one request pending.
        restart(1, 1'b0, 1'b1);
        tick();                     // c1: request 0x0 accepted
        tick();                     // c2: response buffered, memory stalls
        imem_req_ready = 1'b0;
        tick();                     // c3
        #1;
        chk("s7_pre_instr_valid", 32'(instr_valid),    32'd1);
        chk("s7_pre_req_valid",   32'(imem_req_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("s7_async_instr_valid", 32'(instr_valid),    32'd0);
        chk("s7_async_req_valid",   32'(imem_req_valid), 32'd0);
        chk("s7_async_req_addr",    imem_req_addr,       32'h0);
        restart(1, 1'b1, 1'b1);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        drain("s7");
        chk("s7_restart_acc", acc_log[0], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
